// File: rtl/rgb_colour_decoder_pkg.sv
// Shared constants for the RGB colour decoder: colour codes, channel bit
// positions within the 3-bit code, default threshold and the classify record.
package rgb_colour_decoder_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam logic [7:0] THRESH_DEFAULT = 8'h80;

  typedef struct packed {
    logic [2:0] code;
    logic       exact;
  } cls_t;

endpackage

// File: rtl/rgb_colour_decoder_classify.sv
// Per-channel classifier, purely combinational: on when value >= THRESH,
// exact when the value is fully off (8'h00) or fully on (8'hFF).
module rgb_channel_classify
  import rgb_colour_decoder_pkg::*;
#(
  parameter logic [7:0] THRESH = THRESH_DEFAULT
) (
  input  logic [7:0] chan_dat,
  output logic       on,
  output logic       exact
);

  assign on    = (chan_dat >= THRESH);
  assign exact = (chan_dat == 8'h00) || (chan_dat == 8'hFF);

endmodule

// File: rtl/rgb_colour_decoder.sv
// Recovers a debounced 3-bit colour code from a 24-bit RGB stream; output is
// registered one edge after the completing sample and held until out_ready.
module rgb_colour_decoder
  import rgb_colour_decoder_pkg::*;
#(
  parameter logic [7:0] THRESH     = THRESH_DEFAULT,
  parameter int         STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  colour,
  output logic        exact
);

  localparam logic [3:0] SAT = 4'(STABLE_CNT);

  logic [2:0] on_bit;
  logic [2:0] ex_bit;
  cls_t       cls;

  rgb_channel_classify #(.THRESH(THRESH)) u_cls_r (
    .chan_dat(rgb[23:16]), .on(on_bit[CH_R]), .exact(ex_bit[CH_R]));
  rgb_channel_classify #(.THRESH(THRESH)) u_cls_g (
    .chan_dat(rgb[15:8]),  .on(on_bit[CH_G]), .exact(ex_bit[CH_G]));
  rgb_channel_classify #(.THRESH(THRESH)) u_cls_b (
    .chan_dat(rgb[7:0]),   .on(on_bit[CH_B]), .exact(ex_bit[CH_B]));

  always_comb begin
    cls.code  = on_bit;
    cls.exact = &ex_bit;
  end

  logic [2:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] committed_q, committed_d;
  logic       have_q, have_d;
  logic [2:0] colour_q, colour_d;
  logic       exact_q, exact_d;
  logic       out_valid_q, out_valid_d;
  logic       in_acc;
  logic       emit;

  // A pending output blocks input unless it is being consumed this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    have_d      = have_q;
    colour_d    = colour_q;
    exact_d     = exact_q;
    out_valid_d = out_valid_q;
    emit        = 1'b0;

    if (in_acc) begin
      if (cls.code == cand_q) begin
        cnt_d = (cnt_q >= SAT) ? SAT : cnt_q + 4'd1;
      end else begin
        cand_d = cls.code;
        cnt_d  = 4'd1;
      end
      emit = (cnt_d == SAT) && (!have_q || (cand_d != committed_q));
    end

    if (emit) begin
      colour_d    = cand_d;
      exact_d     = cls.exact;
      committed_d = cand_d;
      have_d      = 1'b1;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= 3'b000;
      cnt_q       <= 4'd0;
      committed_q <= 3'b000;
      have_q      <= 1'b0;
      colour_q    <= 3'b000;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      have_q      <= have_d;
      colour_q    <= colour_d;
      exact_q     <= exact_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign colour    = colour_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_rgb_colour_decoder.sv
// Bench for rgb_colour_decoder: vector table plus scoreboard on the main
// instance, and a STABLE_CNT=1 instance for the same-cycle reload case.
module tb_rgb_colour_decoder;
  import rgb_colour_decoder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] rgb;
  logic        in_ready, out_valid, exact;
  logic [2:0]  colour;
  logic        in_ready1, out_valid1, exact1;
  logic [2:0]  colour1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] colour;
    logic       exact;
  } exp_t;

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  colour;
    logic        exact;
  } vec_t;

  exp_t sb_q[$];

  rgb_colour_decoder #(.THRESH(8'h80), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rgb(rgb), .out_valid(out_valid), .out_ready(out_ready),
    .colour(colour), .exact(exact));

  rgb_colour_decoder #(.THRESH(8'h80), .STABLE_CNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .rgb(rgb), .out_valid(out_valid1), .out_ready(out_ready),
    .colour(colour1), .exact(exact1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [23:0] d, input logic v, input logic r);
    rgb       = d;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a handshake happens on the next edge whenever both are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {28'd0, colour, exact}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_colour", {29'd0, colour}, {29'd0, e.colour});
        check("sb_exact", {31'd0, exact}, {31'd0, e.exact});
      end
    end
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = '{24'h00FF00, GREEN,   1'b1};
    vecs[1] = '{24'h000000, BLACK,   1'b1};
    vecs[2] = '{24'h0000FF, BLUE,    1'b1};
    vecs[3] = '{24'h00FFFF, CYAN,    1'b1};
    vecs[4] = '{24'hFF0000, RED,     1'b1};
    vecs[5] = '{24'hFF00FF, MAGENTA, 1'b1};
    vecs[6] = '{24'hFFFF00, YELLOW,  1'b1};
    vecs[7] = '{24'hFFFFFF, WHITE,   1'b1};
    vecs[8] = '{24'h807F80, MAGENTA, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rgb       = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_colour", {29'd0, colour}, 32'd0);
    check("rst_exact", {31'd0, exact}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Each code three times; output must appear on the third accept only.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rgb, 1'b1, 1'b1);
      check("vec_no_out_1", {31'd0, out_valid}, 32'd0);
      step(vecs[i].rgb, 1'b1, 1'b1);
      check("vec_no_out_2", {31'd0, out_valid}, 32'd0);
      sb_q.push_back('{vecs[i].colour, vecs[i].exact});
      step(vecs[i].rgb, 1'b1, 1'b1);
      check("vec_out_3", {31'd0, out_valid}, 32'd1);
    end

    // Glitch in the middle of a run produces nothing until RED is stable.
    step(24'hFF0000, 1'b1, 1'b1); check("deb_1", {31'd0, out_valid}, 32'd0);
    step(24'hFF0000, 1'b1, 1'b1); check("deb_2", {31'd0, out_valid}, 32'd0);
    step(24'h0000FF, 1'b1, 1'b1); check("deb_3", {31'd0, out_valid}, 32'd0);
    step(24'hFF0000, 1'b1, 1'b1); check("deb_4", {31'd0, out_valid}, 32'd0);
    step(24'hFF0000, 1'b1, 1'b1); check("deb_5", {31'd0, out_valid}, 32'd0);
    sb_q.push_back('{RED, 1'b1});
    step(24'hFF0000, 1'b1, 1'b1); check("deb_6", {31'd0, out_valid}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      step(24'hFF0000, 1'b1, 1'b1);
      check("norep_hold", {31'd0, out_valid}, 32'd0);
    end
    step(24'h0000FF, 1'b1, 1'b1);
    step(24'h0000FF, 1'b1, 1'b1);
    sb_q.push_back('{BLUE, 1'b1});
    step(24'h0000FF, 1'b1, 1'b1); check("blue_out", {31'd0, out_valid}, 32'd1);
    repeat (3) step(24'h0000FF, 1'b1, 1'b1);
    check("blue_once", {31'd0, out_valid}, 32'd0);

    // Backpressure: emit MAGENTA and stall; stalled CYAN samples are dropped.
    step(24'hFF00FF, 1'b1, 1'b0);
    step(24'hFF00FF, 1'b1, 1'b0);
    sb_q.push_back('{MAGENTA, 1'b1});
    step(24'hFF00FF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(24'h00FFFF, 1'b1, 1'b0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_colour", {29'd0, colour}, {29'd0, MAGENTA});
    end
    step(24'h00FFFF, 1'b0, 1'b1);
    check("bp_drain", {31'd0, out_valid}, 32'd0);
    step(24'h00FFFF, 1'b1, 1'b0); check("bp_cyan_1", {31'd0, out_valid}, 32'd0);
    step(24'h00FFFF, 1'b1, 1'b0); check("bp_cyan_2", {31'd0, out_valid}, 32'd0);
    sb_q.push_back('{CYAN, 1'b1});
    step(24'h00FFFF, 1'b1, 1'b0); check("bp_cyan_3", {31'd0, out_valid}, 32'd1);

    // STABLE_CNT=1 instance: pending GREEN consumed while YELLOW emits.
    step(24'hFF0000, 1'b1, 1'b1);
    step(24'hFF0000, 1'b1, 1'b1);
    check("s1_idle", {31'd0, out_valid1}, 32'd0);
    step(24'h00FF00, 1'b1, 1'b0);
    check("s1_green_vld", {31'd0, out_valid1}, 32'd1);
    check("s1_green", {29'd0, colour1}, {29'd0, GREEN});
    step(24'hFFFF00, 1'b1, 1'b1);
    check("s1_sim_vld", {31'd0, out_valid1}, 32'd1);
    check("s1_sim_colour", {29'd0, colour1}, {29'd0, YELLOW});
    step(24'hFFFF00, 1'b1, 1'b1);
    check("s1_norep", {31'd0, out_valid1}, 32'd0);

    // Main instance now holds YELLOW x2; third emits, then reset drops it.
    step(24'hFFFF00, 1'b1, 1'b0);
    check("rst_pend_vld", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_vld", {31'd0, out_valid}, 32'd0);
    check("rst_mid_colour", {29'd0, colour}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(24'hFFFF00, 1'b1, 1'b1); check("rst_cnt_1", {31'd0, out_valid}, 32'd0);
    step(24'hFFFF00, 1'b1, 1'b1); check("rst_cnt_2", {31'd0, out_valid}, 32'd0);
    sb_q.push_back('{YELLOW, 1'b1});
    step(24'hFFFF00, 1'b1, 1'b1); check("rst_cnt_3", {31'd0, out_valid}, 32'd1);
    step(24'hFFFF00, 1'b0, 1'b1);
    step(24'hFFFF00, 1'b0, 1'b1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_colour_decoder.md
Name: rgb_colour_decoder

Overview:
- Inverse of the RGB light driver: accepts 24-bit RGB words over a valid/ready stream and recovers the 3-bit colour code (bit2=R, bit1=G, bit0=B).
- Thresholds each 8-bit channel and debounces the result: a code is only reported after STABLE_CNT consecutive accepted samples agree.
- Reports each newly stable code once, on an output valid/ready handshake.
- Sits between a sensor/pixel source and colour-code consumers.

Parameters:
- THRESH, 8'h80, channel is "on" when channel value >= THRESH.
- STABLE_CNT, 3, consecutive identical codes required before reporting (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  rgb is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- rgb  input  24  {R[23:16], G[15:8], B[7:0]}.
- out_valid  output  1  colour/exact hold a new stable code.
- out_ready  input  1  consumer takes the output this cycle.
- colour  output  3  decoded stable code.
- exact  output  1  the completing sample had every channel exactly 8'h00 or 8'hFF.

Behaviour:
- Reset (async assert, sync release):
  - colour=0, exact=0, out_valid=0.
  - Internal cand=0, cnt=0, committed=0, have_committed=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Samples with in_valid && !in_ready are ignored: no cnt change, no state change.
- Classify (combinational):
  - code = {R>=THRESH, G>=THRESH, B>=THRESH}.
  - ex = each channel is 8'h00 or 8'hFF.
- Debounce, on each accepted sample:
  - If code==cand: cnt <= min(cnt+1, STABLE_CNT).
  - Else: cand <= code; cnt <= 1.
  - cnt width = 4 bits; saturates, never wraps.
- Emit condition (evaluated on an accept):
  - The new cnt value equals STABLE_CNT (i.e. the transition into STABLE_CNT, or code==committed is false while saturated — see below).
  - AND (!have_committed || new cand != committed).
  - Net effect: first stable code after reset is always reported, including 3'b000.
  - A stable code equal to committed is not re-reported.
  - A→B→A flicker shorter than STABLE_CNT produces no output.
- On emit, same edge:
  - colour <= new cand; exact <= ex of the completing sample.
  - committed <= new cand; have_committed <= 1.
  - out_valid <= 1.
- Latency: out_valid rises on the edge that accepts the STABLE_CNT-th matching sample (one clock after the sample is presented).
- out_valid stays high, and colour/exact stay stable, until out_ready is sampled high.
- Simultaneous out_valid && out_ready && emit: outputs reload with the new code and out_valid stays 1; no bubble, no loss.
- out_ready without emit: out_valid <= 0 next edge.
- STABLE_CNT=1: every accepted sample whose code differs from committed emits.
- Reset mid-stream (rst_n low at any time): all state cleared immediately. Any pending output is dropped; out_valid=0 while rst_n is low.
- No combinational path from rgb to any output. The only combinational path from out_ready is to in_ready.

Decomposition:
- Shared package holds:
  - Colour code localparams: BLACK=3'b000 … WHITE=3'b111.
  - Channel bit-index constants: R=2, G=1, B=0.
  - Default THRESH value.
- One natural sub-module: rgb_channel_classify (purely combinational, one 8-bit channel -> on bit + exact bit), instantiated three times.
- Debounce, handshake and output registers live in the top module.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and rgb=24'hFFFFFF -> out_valid=0, colour=0, in_ready=1. Release rst_n -> no output until 3 accepts.
- Basic decode: out_ready=1, rgb=24'h00FF00 for 3 accepted cycles -> out_valid on the 3rd accept edge, colour=3'b010, exact=1, out_valid low the next cycle. Repeat for all 8 pure codes; also rgb=24'h807F80 -> colour=3'b101, exact=0.
- Debounce: sequence FF0000, FF0000, 0000FF, FF0000 ×3 -> single output colour=3'b100 only after the final 3rd FF0000; the 0000FF glitch yields nothing.
- No repeat: after colour 3'b100 is reported, hold FF0000 for 10 more accepts -> no further out_valid. Then 6 × 0000FF -> exactly one output, colour=3'b001.
- Backpressure: out_ready=0 after an emit -> in_ready=0, out_valid held, colour stable. Stream 00FFFF during the stall -> ignored (cnt unchanged). Raise out_ready -> handshake completes; 3 × 00FFFF then yields colour=3'b011.
- Simultaneous: output pending with out_ready=1 on the same cycle as the 3rd matching FFFF00 -> out_valid stays 1, colour updates to 3'b110. Then assert rst_n=0 mid-count -> out_valid=0 immediately and the count restarts after release.
